dino_jump_engine: RTL and testbench

Parametrised successor to the dinosaur jump/sprite block. It runs the player game-state machine, computes a frame-stepped parabolic jump height and emits the dinosaur sprite pixel for the current VGA scan position. It also detects sprite/obstacle pixel collisions. It sits between the VGA timing generator (row/col, frame strobe) and the pixel mixer, alongside the obstacle generator.

---
 rtl/dino_pkg.sv | 22 ++
 rtl/dino_sprite_rom.sv | 24 ++
 rtl/dino_jump_engine.sv | 156 +++++++++++++++
 tb/tb_dino_jump_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and jump-height helper for the dinosaur jump engine.
package dino_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StAir, StDead} dino_state_e;

    typedef logic [11:0] height_t;

    localparam int unsigned T_W = 6;

    // Parabolic height above ground for frame t of a jump arc, 12-bit unsigned.
    function automatic height_t dino_height(input logic [T_W-1:0] t,
                                            input int unsigned jump_frames);
        height_t tt;
        height_t rem;
        height_t prod;
        tt   = height_t'(t);
        rem  = height_t'(jump_frames) - tt;
        prod = tt * rem;
        return prod >> 1;
    endfunction

endpackage

// File: rtl/dino_sprite_rom.sv
// Dinosaur sprite bitmap: combinational index -> pixel, contents fixed at elaboration.
module dino_sprite_rom #(
    parameter int unsigned SPR_W = 82,
    parameter int unsigned SPR_H = 88,
    parameter int unsigned IDX_W = $clog2(SPR_W * SPR_H)
) (
    input  logic [IDX_W-1:0] idx,
    output logic             pixel
);

    localparam int unsigned DEPTH = SPR_W * SPR_H;

    logic [DEPTH-1:0] bitmap;

    // Diagonal stripe pattern: pixel (x, y) is lit unless (x + 2y) is a multiple of 5.
    for (genvar y = 0; y < int'(SPR_H); y++) begin : g_row
        for (genvar x = 0; x < int'(SPR_W); x++) begin : g_col
            assign bitmap[y*SPR_W+x] = ((x + 2 * y) % 5) != 0;
        end
    end

    assign pixel = (32'(idx) < DEPTH) ? bitmap[idx] : 1'b0;

endmodule

// File: rtl/dino_jump_engine.sv
// Player state machine, frame-stepped jump arc, sprite pixel and collision detect.
// Optional mid-air double jump is enabled by defining DINO_DOUBLE_JUMP_EN.
module dino_jump_engine
    import dino_pkg::*;
#(
    parameter int unsigned SPR_W       = 82,
    parameter int unsigned SPR_H       = 88,
    parameter int unsigned SPR_X       = 80,
    parameter int unsigned GROUND_Y    = 402,
    parameter int unsigned JUMP_FRAMES = 30,
    parameter int unsigned ROW_W       = 9,
    parameter int unsigned COL_W       = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             fresh,
    input  logic             button_jump,
    input  logic             obs_px,
    input  logic [ROW_W-1:0] row_addr,
    input  logic [COL_W-1:0] col_addr,
    output logic             px,
    output logic             game_status,
    output logic             dead
);

    localparam int unsigned IDX_W = $clog2(SPR_W * SPR_H);
    localparam logic [T_W-1:0] T_FULL = T_W'(JUMP_FRAMES);
    localparam logic [T_W-1:0] T_HALF = T_W'(JUMP_FRAMES / 2);

    dino_state_e    state_q, state_d;
    logic [T_W-1:0] t_q, t_d;
    logic           pending_q, pending_d;
    logic           fresh_q, btn_q, px_q;
    logic           tick, press, hit, playing;
`ifdef DINO_DOUBLE_JUMP_EN
    logic           dj_used_q, dj_used_d;
`endif

    height_t        h;
    logic [15:0]    row_e, col_e, bottom, top;
    logic           spr_on, rom_bit;
    logic [IDX_W-1:0] rom_idx;

    assign tick  = fresh_q & ~fresh;
    assign press = button_jump & ~btn_q;

    assign h      = dino_height(t_q, JUMP_FRAMES);
    assign row_e  = 16'(row_addr);
    assign col_e  = 16'(col_addr);
    assign bottom = 16'(GROUND_Y) - 16'(h);
    assign top    = bottom - 16'(SPR_H);
    assign spr_on = (row_e >= top) && (row_e < bottom) &&
                    (col_e >= 16'(SPR_X)) && (col_e < 16'(SPR_X + SPR_W));
    assign rom_idx = IDX_W'((col_e - 16'(SPR_X)) + (row_e - top) * 16'(SPR_W));

    dino_sprite_rom #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .IDX_W (IDX_W)
    ) u_rom (
        .idx   (rom_idx),
        .pixel (rom_bit)
    );

    assign playing = (state_q == StRun) || (state_q == StAir);
    assign hit     = spr_on & rom_bit & obs_px & playing;

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        pending_d = pending_q;
`ifdef DINO_DOUBLE_JUMP_EN
        dj_used_d = dj_used_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (press) begin
                    state_d = StRun;
`ifdef DINO_DOUBLE_JUMP_EN
                    dj_used_d = 1'b0;
`endif
                end
            end
            StRun: begin
                if (hit) begin
                    state_d = StDead;
                end else if (tick && pending_q) begin
                    state_d   = StAir;
                    t_d       = T_W'(1);
                    pending_d = 1'b0;
                end else if (press) begin
                    pending_d = 1'b1;
                end
            end
            StAir: begin
                if (hit) begin
                    state_d = StDead;
                end else if (tick) begin
                    if (t_q == T_FULL) begin
                        state_d = StRun;
                        t_d     = '0;
`ifdef DINO_DOUBLE_JUMP_EN
                        dj_used_d = 1'b0;
`endif
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
`ifdef DINO_DOUBLE_JUMP_EN
                // Mirror t onto the ascending half: same height, climbs again.
                else if (press && !dj_used_q && (t_q > T_HALF)) begin
                    t_d       = T_FULL - t_q;
                    dj_used_d = 1'b1;
                end
`endif
            end
            StDead: begin
                if (press) begin
                    state_d   = StIdle;
                    t_d       = '0;
                    pending_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            t_q       <= '0;
            pending_q <= 1'b0;
            fresh_q   <= 1'b0;
            btn_q     <= 1'b0;
            px_q      <= 1'b0;
`ifdef DINO_DOUBLE_JUMP_EN
            dj_used_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            pending_q <= pending_d;
            fresh_q   <= fresh;
            btn_q     <= button_jump;
            px_q      <= spr_on & rom_bit;
`ifdef DINO_DOUBLE_JUMP_EN
            dj_used_q <= dj_used_d;
`endif
        end
    end

    assign px          = px_q;
    assign game_status = playing;
    assign dead        = (state_q == StDead);

endmodule

// File: tb/tb_dino_jump_engine.sv
// Directed bench for dino_jump_engine with default parameters; honours DINO_DOUBLE_JUMP_EN.
module tb_dino_jump_engine;

`ifdef DINO_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       fresh = 1'b0;
    logic       button_jump = 1'b0;
    logic       obs_px = 1'b0;
    logic [8:0] row_addr = '0;
    logic [9:0] col_addr = '0;
    logic       px, game_status, dead;

    int total = 0;
    int bad   = 0;

    dino_jump_engine dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .fresh       (fresh),
        .button_jump (button_jump),
        .obs_px      (obs_px),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .px          (px),
        .game_status (game_status),
        .dead        (dead)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int row;
        int col;
        int exp_px;
    } pix_vec_t;

    pix_vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe(input int row, input int col, output int p);
        row_addr = 9'(row);
        col_addr = 10'(col);
        cyc();
        p = int'(px);
    endtask

    task automatic press_btn();
        button_jump = 1'b1;
        cyc();
        button_jump = 1'b0;
        cyc();
    endtask

    task automatic tick();
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        cyc();
    endtask

    // Column 81 is sprite x=1, lit on sprite row 0; the row above the sprite is dark.
    task automatic check_h(input string name, input int exp_h);
        int p;
        int tp;
        tp = 402 - exp_h - 88;
        probe(tp, 81, p);
        check({name, " top"}, p, 1);
        probe(tp - 1, 81, p);
        check({name, " above"}, p, 0);
        row_addr = '0;
        col_addr = '0;
    endtask

    function automatic int hm(input int t);
        return (t * (30 - t)) / 2;
    endfunction

    function automatic int rom_px(input int x, input int y);
        return (((x + 2 * y) % 5) != 0) ? 1 : 0;
    endfunction

    initial begin
        int p;
        int t_m;
        bit dj_m;
        bit landed;
        bit p2;

        vecs[0]  = '{313, 81, 0};
        vecs[1]  = '{314, 80, 0};
        vecs[2]  = '{314, 81, 1};
        vecs[3]  = '{314, 85, 0};
        vecs[4]  = '{314, 86, 1};
        vecs[5]  = '{314, 161, 1};
        vecs[6]  = '{314, 162, 0};
        vecs[7]  = '{314, 79, 0};
        vecs[8]  = '{315, 83, 0};
        vecs[9]  = '{315, 80, 1};
        vecs[10] = '{401, 80, 1};
        vecs[11] = '{401, 82, 1};
        vecs[12] = '{402, 80, 0};
        vecs[13] = '{402, 81, 0};

        // Reset held with the scan on a lit IDLE pixel: px must stay 0.
        RESET = 1'b1;
        row_addr = 9'd314;
        col_addr = 10'd81;
        repeat (3) cyc();
        check("px in reset", int'(px), 0);
        check("status in reset", int'(game_status), 0);
        RESET = 1'b0;
        row_addr = '0;
        col_addr = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("idle px", int'(px), 0);
            check("idle status", int'(game_status), 0);
            check("idle dead", int'(dead), 0);
        end

        button_jump = 1'b1;
        cyc();
        check("start status", int'(game_status), 1);
        check("start dead", int'(dead), 0);
        button_jump = 1'b0;
        cyc();

        // Ground-level window in RUN.
        for (int i = 0; i < 14; i++) begin
            probe(vecs[i].row, vecs[i].col, p);
            check($sformatf("vec%0d r%0d c%0d", i, vecs[i].row, vecs[i].col), p, vecs[i].exp_px);
        end

        // Stream sprite row 0 one column per clock; px follows one edge behind.
        row_addr = 9'd314;
        for (int c = 80; c < 162; c++) begin
            col_addr = 10'(c);
            cyc();
            check($sformatf("row0 c%0d", c), int'(px), rom_px(c - 80, 0));
        end
        row_addr = '0;
        col_addr = '0;

        // Press mid-frame; the next tick launches.
        tick();
        repeat (5) cyc();
        press_btn();
        repeat (5) cyc();
        tick();
        check_h("t1 h14", 14);
        for (int i = 2; i <= 15; i++) tick();
        check_h("t15 h112", 112);
        probe(202, 81, p);
        check("t15 row202", p, 1);
        probe(289, 80, p);
        check("t15 bottom", p, 1);
        probe(290, 80, p);
        check("t15 below", p, 0);
        for (int i = 16; i <= 20; i++) tick();
        check_h("t20 h100", 100);

        // Press on the descent; second press later always ignored.
        t_m  = 20;
        dj_m = 1'b0;
        press_btn();
        if (DJ && !dj_m && t_m > 15) begin
            t_m  = 30 - t_m;
            dj_m = 1'b1;
        end
        check_h("after press", hm(t_m));
        landed = 1'b0;
        p2 = 1'b0;
        for (int k = 0; k < 40 && !landed; k++) begin
            if (t_m == 25 && !p2) begin
                press_btn();
                p2 = 1'b1;
                check_h("second press", hm(t_m));
            end
            tick();
            if (t_m == 30) begin
                landed = 1'b1;
                t_m = 0;
            end else begin
                t_m++;
            end
            check_h($sformatf("arc t%0d", t_m), hm(t_m));
        end
        check("landed in budget", int'(landed), 1);
        tick();
        check_h("run after land", 0);
        check("run status", int'(game_status), 1);

        // Relaunch proves RUN; collide at t=10.
        press_btn();
        tick();
        check_h("relaunch h14", 14);
        for (int i = 2; i <= 10; i++) tick();
        check_h("t10 h100", 100);
        row_addr = 9'd214;
        col_addr = 10'd81;
        obs_px = 1'b1;
        cyc();
        obs_px = 1'b0;
        check("collide dead", int'(dead), 1);
        check("collide status", int'(game_status), 0);
        repeat (3) tick();
        check_h("dead frozen", 100);
        check("still dead", int'(dead), 1);
        press_btn();
        check("to idle dead", int'(dead), 0);
        check("to idle status", int'(game_status), 0);
        check_h("idle ground", 0);

        // Collision in the same cycle as a tick at t=5 (h=62, top 252).
        press_btn();
        press_btn();
        tick();
        for (int i = 2; i <= 5; i++) tick();
        check_h("t5 h62", 62);
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        row_addr = 9'd252;
        col_addr = 10'd81;
        obs_px = 1'b1;
        cyc();
        obs_px = 1'b0;
        check("tick+hit dead", int'(dead), 1);
        check_h("tick+hit t held", 62);
        press_btn();
        check("tick+hit idle", int'(dead), 0);

        // Reset mid-jump at t=8 (h=88, top 226) with scan on a lit pixel.
        press_btn();
        press_btn();
        tick();
        for (int i = 2; i <= 8; i++) tick();
        check_h("t8 h88", 88);
        row_addr = 9'd226;
        col_addr = 10'd81;
        RESET = 1'b1;
        cyc();
        check("mid reset px", int'(px), 0);
        check("mid reset status", int'(game_status), 0);
        RESET = 1'b0;
        cyc();
        check("post reset px", int'(px), 0);
        check_h("post reset ground", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
